// File: rtl/loader_pkg.sv
// Shared constants for the boot-time program loader: state encodings and stream geometry.
package loader_pkg;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned ADDR_STRIDE = 4;
  localparam int unsigned LEN_W       = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

endpackage

// File: rtl/word_assembler.sv
// Big-endian 8-to-32 assembler; word/word_valid are combinational so the
// consumer can register the completed word on the same edge as the 4th byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);

  logic [23:0] head;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      cnt  <= '0;
    end else if (clear) begin
      head <= '0;
      cnt  <= '0;
    end else if (byte_en) begin
      head <= {head[15:0], byte_data};
      cnt  <= cnt + 2'd1;
    end
  end

  assign word       = {head, byte_data};
  assign word_valid = byte_en && (cnt == LAST);

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> cpu instruction-initialize writes,
// holding the cpu in reset until the last word has been held long enough.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = 64,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] HOLD_LAST = LEN_W'(HOLD_CYCLES - 1);

  logic [2:0]       state, state_next;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len, len_in, word_idx, hold_cnt;
  logic             xfer, rearm, word_valid;
  logic [31:0]      word;

  assign xfer   = byte_valid && byte_ready;
  assign len_in = {len_hi, byte_data};
  assign rearm  = start && (state == IDLE || state == DONE || state == ERR);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (rearm),
    .byte_en    (xfer && state == DATA),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN_HI;
      LEN_HI:          if (xfer) state_next = LEN_LO;
      LEN_LO: begin
        if (xfer) state_next = (len_in == '0 || len_in > MAX_LEN) ? ERR : DATA;
      end
      DATA:            if (word_valid && (word_idx + 16'd1 == len)) state_next = HOLD;
      HOLD:            if (hold_cnt == HOLD_LAST) state_next = DONE;
      default:         state_next = IDLE;
    endcase
  end

  // Status outputs are registered from state_next so they line up with the new state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                          <= IDLE;
      byte_ready                     <= 1'b0;
      initialize                     <= 1'b1;
      cpu_rst                        <= 1'b1;
      done                           <= 1'b0;
      error                          <= 1'b0;
      instruction_initialize_data    <= '0;
      instruction_initialize_address <= '0;
      words_loaded                   <= '0;
      len_hi                         <= '0;
      len                            <= '0;
      word_idx                       <= '0;
      hold_cnt                       <= '0;
    end else begin
      state      <= state_next;
      byte_ready <= (state_next == LEN_HI) || (state_next == LEN_LO) || (state_next == DATA);
      initialize <= (state_next != DONE);
      cpu_rst    <= (state_next != DONE);
      done       <= (state_next == DONE);
      error      <= (state_next == ERR);

      if (rearm) begin
        instruction_initialize_data    <= '0;
        instruction_initialize_address <= '0;
        words_loaded                   <= '0;
      end

      if (state == LEN_HI && xfer) len_hi <= byte_data;
      if (state == LEN_LO && xfer) begin
        len      <= len_in;
        word_idx <= '0;
      end

      if (word_valid) begin
        instruction_initialize_data    <= word;
        instruction_initialize_address <= 32'(word_idx) * 32'(ADDR_STRIDE);
        words_loaded                   <= word_idx + 16'd1;
        word_idx                       <= word_idx + 16'd1;
      end

      if (state == HOLD) hold_cnt <= hold_cnt + 16'd1;
      else               hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stream loads, length errors, gaps, async reset, re-arm.
module tb_program_loader;

  localparam logic [31:0] W0 = 32'h0002_0820;
  localparam logic [31:0] W1 = 32'h0084_4022;

  logic        clk, rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, initialize, cpu_rst, done, error;
  logic [31:0] data, addr;
  logic [15:0] words_loaded;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  stream1 [10];
  logic [31:0] mem [64];
  logic        mon_en = 1'b0;
  logic        mon_was = 1'b0;
  logic [63:0] prev;
  int unsigned changes = 0;
  int unsigned bad = 0;

  program_loader #(.MAX_WORDS(64), .HOLD_CYCLES(2)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .byte_valid                     (byte_valid),
    .byte_data                      (byte_data),
    .byte_ready                     (byte_ready),
    .initialize                     (initialize),
    .instruction_initialize_data    (data),
    .instruction_initialize_address (addr),
    .cpu_rst                        (cpu_rst),
    .done                           (done),
    .error                          (error),
    .words_loaded                   (words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watches outputs during the gapped load: change count, partial words, memory image.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!mon_was) begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        prev    = {data, addr};
        changes = 0;
        bad     = 0;
      end else if ({data, addr} !== prev) begin
        changes++;
        prev = {data, addr};
      end
      if (data !== 32'h0 && data !== W0 && data !== W1) bad++;
      if (initialize) mem[addr[7:2]] = data;
    end
    mon_was = mon_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, output bit ok);
    int unsigned n;
    byte_valid = 1'b0;
    for (int unsigned i = 0; i < gap; i++) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    ok = byte_ready;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input int unsigned from, input int unsigned to,
                            input int unsigned maxgap, output bit ok);
    bit b_ok;
    ok = 1'b1;
    for (int unsigned i = from; i < to; i++) begin
      send_byte(stream1[i], $urandom_range(maxgap, 0), b_ok);
      ok = ok & b_ok;
    end
  endtask

  task automatic wait_done(output bit ok);
    int unsigned n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    checks++; if (initialize !== 1'b1) begin errors++; $display("FAIL reset_init: got %b expected 1", initialize); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    checks++; if ({data, addr} !== 64'h0) begin errors++; $display("FAIL reset_data_addr: got %h expected 0", {data, addr}); end
    checks++; if ({byte_ready, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {byte_ready, done, error}); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
    rst = 1'b1;
    tick();
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", byte_ready); end
  endtask

  task automatic test_load();
    bit ok;
    do_start();
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL load_armed_ready: got %b expected 1", byte_ready); end
    send_range(0, 6, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL load_stream_a: got stall expected ready"); end
    checks++; if ({addr, data} !== {32'h0, W0}) begin errors++; $display("FAIL load_word0: got %h/%h expected 0/%h", addr, data, W0); end
    checks++; if (words_loaded !== 16'd1) begin errors++; $display("FAIL load_words1: got %0d expected 1", words_loaded); end
    send_range(6, 10, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL load_stream_b: got stall expected ready"); end
    checks++; if ({addr, data} !== {32'h4, W1}) begin errors++; $display("FAIL load_word1: got %h/%h expected 4/%h", addr, data, W1); end
    checks++; if ({initialize, cpu_rst, done} !== 3'b110) begin errors++; $display("FAIL load_hold0: got %b expected 110", {initialize, cpu_rst, done}); end
    tick();
    checks++; if ({initialize, cpu_rst, done} !== 3'b110) begin errors++; $display("FAIL load_hold1: got %b expected 110", {initialize, cpu_rst, done}); end
    tick();
    checks++; if ({initialize, cpu_rst, done} !== 3'b001) begin errors++; $display("FAIL load_release: got %b expected 001", {initialize, cpu_rst, done}); end
    checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL load_words2: got %0d expected 2", words_loaded); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b expected 0", byte_ready); end
  endtask

  task automatic test_zero_len();
    bit ok, ok2;
    do_start();
    checks++; if ({initialize, cpu_rst, done} !== 3'b110) begin errors++; $display("FAIL rearm_flags: got %b expected 110", {initialize, cpu_rst, done}); end
    checks++; if ({data, addr, words_loaded} !== 80'h0) begin errors++; $display("FAIL rearm_clear: got %h expected 0", {data, addr, words_loaded}); end
    send_byte(8'h00, 0, ok);
    send_byte(8'h00, 0, ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL zero_stream: got stall expected ready"); end
    checks++; if ({error, byte_ready, initialize, cpu_rst} !== 4'b1011) begin errors++; $display("FAIL zero_err: got %b expected 1011", {error, byte_ready, initialize, cpu_rst}); end
    tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL zero_sticky: got %b expected 1", error); end
    do_start();
    checks++; if ({error, byte_ready} !== 2'b01) begin errors++; $display("FAIL zero_restart: got %b expected 01", {error, byte_ready}); end
  endtask

  task automatic test_too_long();
    bit ok, ok2;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_start();
    send_byte(8'h00, 0, ok);
    send_byte(8'h41, 0, ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL long_stream: got stall expected ready"); end
    checks++; if ({error, byte_ready} !== 2'b10) begin errors++; $display("FAIL long_err: got %b expected 10", {error, byte_ready}); end
    checks++; if ({data, addr} !== 64'h0) begin errors++; $display("FAIL long_no_write: got %h expected 0", {data, addr}); end
    do_start();
    send_byte(8'h00, 0, ok);
    send_byte(8'h40, 0, ok2);
    checks++; if ({ok, ok2, error, byte_ready} !== 4'b1101) begin errors++; $display("FAIL max_len_accept: got %b expected 1101", {ok, ok2, error, byte_ready}); end
  endtask

  task automatic test_gaps();
    bit ok, ok2;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_start();
    mon_en = 1'b1;
    send_range(0, 10, 5, ok);
    wait_done(ok2);
    tick();
    mon_en = 1'b0;
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL gap_complete: got stream=%b done=%b expected 1/1", ok, ok2); end
    checks++; if ({mem[0], mem[1]} !== {W0, W1}) begin errors++; $display("FAIL gap_image: got %h %h expected %h %h", mem[0], mem[1], W0, W1); end
    checks++; if (changes != 2) begin errors++; $display("FAIL gap_changes: got %0d expected 2", changes); end
    checks++; if (bad != 0) begin errors++; $display("FAIL gap_partial: got %0d partial words expected 0", bad); end
    checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL gap_words: got %0d expected 2", words_loaded); end
  endtask

  task automatic test_async_reset();
    bit ok, ok2;
    do_start();
    send_range(0, 8, 0, ok);
    checks++; if (data !== W0) begin errors++; $display("FAIL ares_pre: got %h expected %h", data, W0); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({initialize, cpu_rst, byte_ready, done, error} !== 5'b11000) begin errors++; $display("FAIL ares_flags: got %b expected 11000", {initialize, cpu_rst, byte_ready, done, error}); end
    checks++; if ({data, addr, words_loaded} !== 80'h0) begin errors++; $display("FAIL ares_regs: got %h expected 0", {data, addr, words_loaded}); end
    #2 rst = 1'b1;
    tick();
    do_start();
    send_range(0, 10, 0, ok);
    wait_done(ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL ares_reload: got stream=%b done=%b expected 1/1", ok, ok2); end
    checks++; if ({addr, data, words_loaded} !== {32'h4, W1, 16'd2}) begin errors++; $display("FAIL ares_result: got %h/%h/%0d expected 4/%h/2", addr, data, words_loaded, W1); end
  endtask

  task automatic test_start_ignored();
    bit ok, ok2;
    do_start();
    send_range(0, 4, 0, ok);
    start = 1'b1;
    send_byte(stream1[4], 0, ok2);
    start = 1'b0;
    checks++; if ({byte_ready, error, words_loaded} !== {1'b1, 1'b0, 16'd0}) begin errors++; $display("FAIL ign_state: got %b/%b/%0d expected 1/0/0", byte_ready, error, words_loaded); end
    send_range(5, 10, 0, ok);
    wait_done(ok2);
    checks++; if ({addr, data, words_loaded} !== {32'h4, W1, 16'd2}) begin errors++; $display("FAIL ign_result: got %h/%h/%0d expected 4/%h/2", addr, data, words_loaded, W1); end
    do_start();
    checks++; if ({initialize, cpu_rst, done} !== 3'b110) begin errors++; $display("FAIL done_rearm: got %b expected 110", {initialize, cpu_rst, done}); end
    send_byte(8'h00, 0, ok);
    send_byte(8'h01, 0, ok2);
    send_byte(8'hDE, 0, ok);
    send_byte(8'hAD, 0, ok);
    send_byte(8'hBE, 0, ok);
    send_byte(8'hEF, 0, ok2);
    checks++; if ({addr, data, words_loaded} !== {32'h0, 32'hDEADBEEF, 16'd1}) begin errors++; $display("FAIL one_word: got %h/%h/%0d expected 0/deadbeef/1", addr, data, words_loaded); end
    tick();
    tick();
    checks++; if ({initialize, cpu_rst, done} !== 3'b001) begin errors++; $display("FAIL one_release: got %b expected 001", {initialize, cpu_rst, done}); end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    stream1 = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h08, 8'h20, 8'h00, 8'h84, 8'h40, 8'h22};
    test_reset();
    test_load();
    test_zero_len();
    test_too_long();
    test_gaps();
    test_async_reset();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
